// File: rtl/fpu_pkg.sv
// ============================================================================
// fpu_pkg
// ----------------------------------------------------------------------------
// Shared FPU definitions: FP32 field widths and bias, rounding-mode enum and
// a packed FP32 struct. Imported by the converter top and its sub-modules.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fpu_pkg;

  localparam int FP32_BIAS  = 127;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  typedef enum logic {
    RM_RNE = 1'b0,
    RM_RTZ = 1'b1
  } rm_e;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
  } fp32_t;

endpackage

`default_nettype wire

// File: rtl/itof_lzc.sv
// ============================================================================
// itof_lzc
// ----------------------------------------------------------------------------
// Combinational leading-zero counter.
// Ports:
//   a    in   W              value to scan
//   cnt  out  $clog2(W)+1    number of leading zeros (W when a == 0)
// Revision: 1.0
// ============================================================================
`default_nettype none

module itof_lzc
  import fpu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]       a,
  output logic [$clog2(W):0] cnt
);

  localparam int CW = $clog2(W) + 1;

  // Scan from LSB upward so the highest set bit is the last one to win.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (a[i]) begin
        cnt = CW'(W - 1 - i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/itof_pipe.sv
// ============================================================================
// itof_pipe
// ----------------------------------------------------------------------------
// Three-stage pipelined integer to IEEE-754 single converter with
// valid/ready handshake, signed/unsigned operands, RNE/RTZ rounding,
// inexact flag and an opaque tag carried alongside each operation.
// Ports:
//   clk, reset (async, active low)
//   in_valid/in_ready, in_op[IN_W], in_signed, in_rm (0 RNE, 1 RTZ),
//   in_tag[TAG_W]
//   out_valid/out_ready, out_result[32], out_inexact, out_tag[TAG_W]
// Revision: 1.0
// ============================================================================
`default_nettype none

module itof_pipe
  import fpu_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_op,
  input  logic             in_signed,
  input  logic             in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_inexact,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LZ_W    = $clog2(IN_W) + 1;
  localparam int FRAC_W  = IN_W - 1;              // normalised value minus hidden bit
  localparam int G_BIT   = FRAC_W - FP32_MAN_W - 1; // guard position inside frac
  localparam int EXP_TOP = FP32_BIAS + IN_W - 1;
  localparam int MAN_CW  = FP32_MAN_W + 1;

  // Stage 1: sign / magnitude
  logic             s1_valid;
  logic             s1_sign;
  logic [IN_W-1:0]  s1_abs;
  logic             s1_zero;
  rm_e              s1_rm;
  logic [TAG_W-1:0] s1_tag;

  // Stage 2: normalised magnitude / exponent
  logic                  s2_valid;
  logic                  s2_sign;
  logic [FRAC_W-1:0]     s2_frac;
  logic [FP32_EXP_W-1:0] s2_exp;
  rm_e                   s2_rm;
  logic [TAG_W-1:0]      s2_tag;

  // Held low for the first edge after reset so in_ready rises cleanly.
  logic ready_en;

  logic load1, load2, load3, accept;
  logic op_neg;
  logic [IN_W-1:0] op_abs;
  logic [LZ_W-1:0] lz;

  // A stage loads when empty or when its contents move on this cycle.
  assign load3    = !out_valid || out_ready;
  assign load2    = !s2_valid || load3;
  assign load1    = !s1_valid || load2;
  assign in_ready = ready_en && load1;
  assign accept   = in_valid && in_ready;

  // Unsigned negate keeps the signed minimum exact (magnitude fits IN_W bits).
  assign op_neg = in_signed && in_op[IN_W-1];
  assign op_abs = op_neg ? -in_op : in_op;

  itof_lzc #(.W(IN_W)) u_lzc (
    .a   (s1_abs),
    .cnt (lz)
  );

  // Stage 3 rounding and packing
  logic [FP32_MAN_W-1:0] mant, mant_rnd;
  logic [FP32_EXP_W-1:0] exp_rnd;
  logic                  guard, sticky, round_up, carry;
  fp32_t                 packed_res;

  always_comb begin
    mant     = s2_frac[FRAC_W-1 -: FP32_MAN_W];
    guard    = s2_frac[G_BIT];
    sticky   = |s2_frac[G_BIT-1:0];
    round_up = (s2_rm == RM_RNE) && guard && (sticky || mant[0]);
    // An all-ones mantissa that rounds up wraps to zero and bumps the exponent.
    {carry, mant_rnd} = {1'b0, mant} + MAN_CW'(round_up);
    exp_rnd  = s2_exp + FP32_EXP_W'(carry);
    packed_res.sign = s2_sign;
    packed_res.exp  = exp_rnd;
    packed_res.man  = mant_rnd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en    <= 1'b0;
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_abs      <= '0;
      s1_zero     <= 1'b0;
      s1_rm       <= RM_RNE;
      s1_tag      <= '0;
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_frac     <= '0;
      s2_exp      <= '0;
      s2_rm       <= RM_RNE;
      s2_tag      <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_inexact <= 1'b0;
      out_tag     <= '0;
    end else begin
      ready_en <= 1'b1;

      if (load1) s1_valid <= accept;
      if (accept) begin
        s1_sign <= op_neg;
        s1_abs  <= op_abs;
        s1_zero <= (in_op == '0);
        s1_rm   <= rm_e'(in_rm);
        s1_tag  <= in_tag;
      end

      if (load2) s2_valid <= s1_valid;
      if (load2 && s1_valid) begin
        s2_sign <= s1_sign;
        // Drop the hidden bit while normalising; zero leaves frac all-zero.
        s2_frac <= FRAC_W'(s1_abs << lz);
        s2_exp  <= s1_zero ? '0 : FP32_EXP_W'(EXP_TOP - int'(lz));
        s2_rm   <= s1_rm;
        s2_tag  <= s1_tag;
      end

      if (load3) out_valid <= s2_valid;
      if (load3 && s2_valid) begin
        out_result  <= packed_res;
        out_inexact <= guard || sticky;
        out_tag     <= s2_tag;
      end
    end
  end

endmodule

`default_nettype wire
